// File: rtl/full_adder_pkg.sv
// Shared constants for the full_adder_unit slice.
//   FA_DEFAULT_WIDTH : default operand width (1 gives the classic 1-bit full adder)
//   *_RST            : values the registered outputs take while rst is high
// Optional feature macro used by the top: FULL_ADDER_OVF_EN (signed overflow flag).
package full_adder_pkg;

    localparam int   FA_DEFAULT_WIDTH = 1;

    localparam logic SUM_RST_BIT = 1'b0;
    localparam logic COUT_RST    = 1'b0;
    localparam logic VLD_RST     = 1'b0;
    localparam logic OVF_RST     = 1'b0;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder cell; chained by full_adder_unit to form the ripple adder.
// Ports:
//   a, b  : operand bits
//   cin   : carry into this bit
//   s     : sum bit, a ^ b ^ cin
//   cout  : carry out, majority(a, b, cin)
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder_unit.sv
// Parameterised ripple-carry adder: {Cout, S} = A + B + Cin, combinational,
// plus a one-cycle registered copy qualified by in_vld.
// Optional feature macro: FULL_ADDER_OVF_EN adds the signed overflow flag
// ovf and its registered copy ovf_q; without it those ports do not exist.
// Ports:
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset of the registered outputs
//   A, B [WIDTH]   : operands
//   Cin            : carry in
//   in_vld         : qualifies A/B/Cin for capture into the registers
//   S [WIDTH]      : combinational sum, wraps mod 2^WIDTH
//   Cout           : combinational carry out
//   sum_q, cout_q  : registered S / Cout, loaded only when in_vld is high
//   vld_q          : registered in_vld
//   ovf, ovf_q     : signed overflow and its registered copy (FULL_ADDER_OVF_EN)
module full_adder_unit
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_vld,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             vld_q
`ifdef FULL_ADDER_OVF_EN
    ,
    output logic             ovf,
    output logic             ovf_q
`endif
);

    // carry[i] feeds bit i; carry[WIDTH] is the adder's carry out
    logic [WIDTH:0] carry;

    assign carry[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_bit u_bit (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (carry[i]),
            .s    (S[i]),
            .cout (carry[i+1])
        );
    end

    assign Cout = carry[WIDTH];

`ifdef FULL_ADDER_OVF_EN
    // Two's-complement overflow: like-signed operands produced an unlike-signed sum
    assign ovf = (A[WIDTH-1] == B[WIDTH-1]) && (S[WIDTH-1] != A[WIDTH-1]);
`endif

    // vld_q follows in_vld every cycle; data registers hold when in_vld is low
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= {WIDTH{SUM_RST_BIT}};
            cout_q <= COUT_RST;
            vld_q  <= VLD_RST;
`ifdef FULL_ADDER_OVF_EN
            ovf_q  <= OVF_RST;
`endif
        end else begin
            vld_q <= in_vld;
            if (in_vld) begin
                sum_q  <= S;
                cout_q <= Cout;
`ifdef FULL_ADDER_OVF_EN
                ovf_q  <= ovf;
`endif
            end
        end
    end

endmodule

// File: tb/tb_full_adder_unit.sv
// Bench for full_adder_unit: a WIDTH=1 instance for the truth table and a
// WIDTH=4 instance for directed boundaries plus random traffic, both checked
// against arithmetic reference values computed here.
module tb_full_adder_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // WIDTH=1 instance
    logic a1, b1, cin1, vld1;
    logic s1, cout1, sum_q1, cout_q1, vld_q1;
`ifdef FULL_ADDER_OVF_EN
    logic ovf1, ovf_q1;
`endif

    // WIDTH=4 instance
    logic [3:0] a4, b4;
    logic       cin4, vld4;
    logic [3:0] s4, sum_q4;
    logic       cout4, cout_q4, vld_q4;
`ifdef FULL_ADDER_OVF_EN
    logic       ovf4, ovf_q4;
`endif

    full_adder_unit #(.WIDTH(1)) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .A      (a1),
        .B      (b1),
        .Cin    (cin1),
        .in_vld (vld1),
        .S      (s1),
        .Cout   (cout1),
        .sum_q  (sum_q1),
        .cout_q (cout_q1),
        .vld_q  (vld_q1)
`ifdef FULL_ADDER_OVF_EN
        ,
        .ovf    (ovf1),
        .ovf_q  (ovf_q1)
`endif
    );

    full_adder_unit #(.WIDTH(4)) u_dut4 (
        .clk    (clk),
        .rst    (rst),
        .A      (a4),
        .B      (b4),
        .Cin    (cin4),
        .in_vld (vld4),
        .S      (s4),
        .Cout   (cout4),
        .sum_q  (sum_q4),
        .cout_q (cout_q4),
        .vld_q  (vld_q4)
`ifdef FULL_ADDER_OVF_EN
        ,
        .ovf    (ovf4),
        .ovf_q  (ovf_q4)
`endif
    );

    int errors = 0;
    int checks = 0;

    // expected register contents of the WIDTH=4 instance
    logic [3:0] exp_sum_q;
    logic       exp_cout_q;
    logic       exp_vld_q;
`ifdef FULL_ADDER_OVF_EN
    logic       exp_ovf_q;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one input set to the WIDTH=4 instance, check the combinational
    // result, clock once, then check the registered outputs.
    task automatic apply4(input logic [3:0] a, input logic [3:0] b,
                          input logic c, input logic v, input logic r);
        int         total;
        int         sa, sb, ssum;
        logic [3:0] es;
        logic       ec;
        logic       eo;
        a4   = a;
        b4   = b;
        cin4 = c;
        vld4 = v;
        rst  = r;
        total = int'(a) + int'(b) + int'(c);
        es    = total[3:0];
        ec    = total[4];
        sa    = (a >= 4'd8) ? int'(a) - 16 : int'(a);
        sb    = (b >= 4'd8) ? int'(b) - 16 : int'(b);
        ssum  = sa + sb + int'(c);
        eo    = (ssum > 7) || (ssum < -8);
        #1;
        check("S4", 32'(s4), 32'(es));
        check("Cout4", 32'(cout4), 32'(ec));
`ifdef FULL_ADDER_OVF_EN
        check("ovf4", 32'(ovf4), 32'(eo));
`endif
        @(posedge clk);
        if (r) begin
            exp_sum_q  = 4'h0;
            exp_cout_q = 1'b0;
            exp_vld_q  = 1'b0;
`ifdef FULL_ADDER_OVF_EN
            exp_ovf_q  = 1'b0;
`endif
        end else begin
            exp_vld_q = v;
            if (v) begin
                exp_sum_q  = es;
                exp_cout_q = ec;
`ifdef FULL_ADDER_OVF_EN
                exp_ovf_q  = eo;
`endif
            end
        end
        #1;
        check("sum_q4", 32'(sum_q4), 32'(exp_sum_q));
        check("cout_q4", 32'(cout_q4), 32'(exp_cout_q));
        check("vld_q4", 32'(vld_q4), 32'(exp_vld_q));
`ifdef FULL_ADDER_OVF_EN
        check("ovf_q4", 32'(ovf_q4), 32'(exp_ovf_q));
`endif
    endtask

    initial begin
        rst  = 1'b1;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; vld1 = 1'b1;
        a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0; vld4 = 1'b1;
        exp_sum_q = 4'h0; exp_cout_q = 1'b0; exp_vld_q = 1'b0;
`ifdef FULL_ADDER_OVF_EN
        exp_ovf_q = 1'b0;
`endif

        // reset state
        @(posedge clk);
        #1;
        check("rst_sum_q4", 32'(sum_q4), 32'h0);
        check("rst_cout_q4", 32'(cout_q4), 32'h0);
        check("rst_vld_q4", 32'(vld_q4), 32'h0);
        check("rst_vld_q1", 32'(vld_q1), 32'h0);
        rst  = 1'b0;
        vld1 = 1'b0;

        // WIDTH=1: Cin toggles every 10ns, B every 20ns, A every 40ns
        #2;
        for (int t = 0; t < 8; t++) begin
            logic [2:0] pat;
            int         tot;
            pat  = 3'(t);
            a1   = pat[2];
            b1   = pat[1];
            cin1 = pat[0];
            tot  = int'(pat[2]) + int'(pat[1]) + int'(pat[0]);
            #1;
            check("S1", 32'(s1), 32'(tot % 2));
            check("Cout1", 32'(cout1), 32'(tot / 2));
            #9;
        end

        // WIDTH=1 registered capture of 1+1+1
        @(posedge clk);
        #1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; vld1 = 1'b1;
        @(posedge clk);
        #1;
        check("sum_q1", 32'(sum_q1), 32'h1);
        check("cout_q1", 32'(cout_q1), 32'h1);
        check("vld_q1", 32'(vld_q1), 32'h1);
        vld1 = 1'b0;
        @(posedge clk);
        #1;

        // WIDTH=4 directed cases
        apply4(4'hF, 4'h0, 1'b1, 1'b1, 1'b0);  // wraps to 0 with carry
        apply4(4'h3, 4'h5, 1'b0, 1'b0, 1'b0);  // in_vld low: hold
        apply4(4'hA, 4'h6, 1'b1, 1'b0, 1'b0);  // still holding
        apply4(4'hF, 4'hF, 1'b1, 1'b1, 1'b1);  // reset beats in_vld
        apply4(4'hF, 4'hF, 1'b1, 1'b1, 1'b0);  // all-ones boundary
        apply4(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);  // all-zero boundary
        apply4(4'h7, 4'h1, 1'b0, 1'b1, 1'b0);  // positive overflow
        apply4(4'h8, 4'h8, 1'b0, 1'b1, 1'b0);  // negative overflow with carry

        // random traffic with occasional mid-stream reset
        for (int i = 0; i < 80; i++) begin
            apply4(4'($urandom_range(15)), 4'($urandom_range(15)),
                   1'($urandom_range(1)), 1'($urandom_range(1)),
                   ($urandom_range(7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
